// File: rtl/unified_mem_arbiter_if.sv
// Stage-side request/response signals and memory-macro signals shared by the
// unified memory arbiter; the arbiter binds the slave modport.
`timescale 1ns/1ps
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_pipe;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_pipe
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_pipe
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch (I) and memory-stage (D) accesses onto one fixed-latency
// single-port memory, returns registered read data and drives pipeline stalls.
`timescale 1ns/1ps
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
  typedef enum logic [1:0] {WIN_NONE, WIN_I, WIN_D} win_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              owner_we_q, owner_we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  win_e              win;

  // Grants are combinational, so they are also gated by reset to keep every
  // grant and memory strobe low while rst is held.
  always_comb begin
    win = WIN_NONE;
    if (rst && state_q == IDLE) begin
      if (bus.d_req && !(bus.if_req && starve_q == STV_LIM)) begin
        win = WIN_D;
      end else if (bus.if_req) begin
        win = WIN_I;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    starve_d   = starve_q;
    owner_we_d = owner_we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (win)
          WIN_I: begin
            state_d    = BUSY_I;
            lat_cnt_d  = '0;
            starve_d   = '0;
            owner_we_d = 1'b0;
          end
          WIN_D: begin
            state_d    = BUSY_D;
            lat_cnt_d  = '0;
            owner_we_d = bus.d_we;
            if (bus.if_req && starve_q != STV_LIM) starve_d = starve_q + STV_W'(1);
          end
          default: ;
        endcase
        if (!bus.if_req) starve_d = '0;
      end
      BUSY_I, BUSY_D: begin
        lat_cnt_d = lat_cnt_q + CNT_W'(1);
        if (lat_cnt_q == LAT_LAST) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            if_rdata_d = bus.mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!owner_we_q) d_rdata_d = bus.mem_rdata;
            d_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      starve_q   <= '0;
      owner_we_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      starve_q   <= starve_d;
      owner_we_q <= owner_we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  // Memory request is steered from the winner during the grant cycle only.
  always_comb begin
    bus.if_gnt    = (win == WIN_I);
    bus.d_gnt     = (win == WIN_D);
    bus.mem_en    = (win != WIN_NONE);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (win)
      WIN_I: bus.mem_addr = bus.if_addr;
      WIN_D: begin
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
      end
      default: ;
    endcase
  end

  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.stall_if   = bus.if_req & ~if_valid_q;
  assign bus.stall_pipe = bus.d_req & ~d_valid_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters, checked
// every cycle against a transaction-timeline model of the arbiter.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory contents: unwritten words hold a hash of their address.
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pipe [0:MEM_LAT];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Fixed-latency memory: data issued in cycle c is on mem_rdata in cycle c+MEM_LAT.
  task automatic mem_step();
    for (int i = MEM_LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = $urandom;
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) mem_arr[bus.mem_addr] = bus.mem_wdata;
      else pipe[0] = mem_read(bus.mem_addr);
    end
    bus.mem_rdata = pipe[MEM_LAT];
  endtask

  // Reference model: a single transaction timeline.
  typedef enum {OWN_NONE, OWN_I, OWN_D} own_e;
  int          free_cyc = 0;
  int          starve   = 0;
  own_e        p_own    = OWN_NONE;
  int          p_due    = 0;
  logic        p_store  = 1'b0;
  logic [31:0] p_data   = '0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;

  task automatic model_step();
    logic e_ig, e_dg, e_iv, e_dv, e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_en = 0; e_we = 0;
    e_addr = '0; e_wdata = '0;
    if (!rst) begin
      free_cyc = cyc; starve = 0; p_own = OWN_NONE;
      exp_if_rdata = '0; exp_d_rdata = '0;
    end else begin
      if (p_own != OWN_NONE && p_due == cyc) begin
        if (p_own == OWN_I) begin
          e_iv = 1; exp_if_rdata = p_data;
        end else begin
          e_dv = 1;
          if (!p_store) exp_d_rdata = p_data;
        end
        p_own = OWN_NONE;
      end
      if (cyc >= free_cyc) begin
        if (bus.d_req && !(bus.if_req && starve == STARVE_MAX)) e_dg = 1;
        else if (bus.if_req) e_ig = 1;
        if (e_ig || !bus.if_req) starve = 0;
        else if (e_dg && starve < STARVE_MAX) starve++;
        if (e_ig) begin
          e_en = 1; e_addr = bus.if_addr;
          p_own = OWN_I; p_store = 0; p_data = ref_read(bus.if_addr);
        end
        if (e_dg) begin
          e_en = 1; e_we = bus.d_we; e_addr = bus.d_addr; e_wdata = bus.d_wdata;
          p_own = OWN_D; p_store = bus.d_we;
          if (bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
          else p_data = ref_read(bus.d_addr);
        end
        if (e_en) begin
          free_cyc = cyc + MEM_LAT + 1;
          p_due    = free_cyc;
        end
      end
    end
    check("if_gnt", bus.if_gnt, e_ig);
    check("d_gnt", bus.d_gnt, e_dg);
    check("mem_en", bus.mem_en, e_en);
    if (e_en || !rst) begin
      check("mem_we", bus.mem_we, e_we);
      check("mem_addr", bus.mem_addr, e_addr);
    end
    if (e_we || !rst) check("mem_wdata", bus.mem_wdata, e_wdata);
    check("if_valid", bus.if_valid, e_iv);
    check("d_valid", bus.d_valid, e_dv);
    check("if_rdata", bus.if_rdata, exp_if_rdata);
    check("d_rdata", bus.d_rdata, exp_d_rdata);
    check("stall_if", bus.stall_if, bus.if_req & ~e_iv);
    check("stall_pipe", bus.stall_pipe, bus.d_req & ~e_dv);
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_end();
    @(negedge clk);
    mem_step();
    model_step();
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      cycle_start();
      cycle_end();
    end
  endtask

  int   seq[$];
  int   lead;
  int   i_st, d_st, rst_hold;
  logic i_granted, d_granted;

  initial begin
    bus.if_req = 1; bus.if_addr = 32'h10;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678;
    bus.mem_rdata = '0;
    for (int i = 0; i <= MEM_LAT; i++) pipe[i] = '0;
    mem_arr[32'h10] = 32'h0050_0093;
    ref_mem[32'h10] = 32'h0050_0093;

    // Requests held during reset must not be granted.
    idle_cycles(3);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    cycle_start(); bus.if_req = 0; bus.d_req = 0; bus.d_we = 0; rst = 1; cycle_end();

    // Single fetch.
    cycle_start(); bus.if_req = 1; bus.if_addr = 32'h10; cycle_end();
    check("fetch_gnt", bus.if_gnt, 1);
    check("fetch_mem_addr", bus.mem_addr, 32'h10);
    check("fetch_mem_we", bus.mem_we, 0);
    check("fetch_stall_T", bus.stall_if, 1);
    for (int k = 0; k < 2; k++) begin
      cycle_start(); cycle_end();
      check("fetch_stall_wait", bus.stall_if, 1);
    end
    cycle_start(); bus.if_req = 0; cycle_end();
    check("fetch_valid", bus.if_valid, 1);
    check("fetch_rdata", bus.if_rdata, 32'h0050_0093);

    // Store.
    cycle_start(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF; cycle_end();
    check("store_mem_we", bus.mem_we, 1);
    check("store_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    idle_cycles(2);
    cycle_start(); bus.d_req = 0; bus.d_we = 0; cycle_end();
    check("store_valid", bus.d_valid, 1);
    check("store_d_rdata", bus.d_rdata, 0);

    // Load and fetch requesting together.
    cycle_start(); bus.d_req = 1; bus.d_addr = 32'h40; bus.if_req = 1; bus.if_addr = 32'h14; cycle_end();
    check("both_d_gnt", bus.d_gnt, 1);
    check("both_if_wait", bus.if_gnt, 0);
    idle_cycles(2);
    cycle_start(); bus.d_req = 0; cycle_end();
    check("load_valid", bus.d_valid, 1);
    check("load_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    check("fetch_after_load", bus.if_gnt, 1);
    idle_cycles(2);
    cycle_start(); bus.if_req = 0; cycle_end();
    check("fetch2_valid", bus.if_valid, 1);
    check("fetch2_rdata", bus.if_rdata, init_val(32'h14));

    // Starvation: both requesters held continuously.
    for (int k = 0; k < 40; k++) begin
      cycle_start();
      if (k == 0) begin
        bus.if_req = 1; bus.if_addr = 32'h18; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
      end
      cycle_end();
      if (bus.d_gnt === 1'b1) seq.push_back(2);
      if (bus.if_gnt === 1'b1) seq.push_back(1);
    end
    lead = 0;
    while (lead < seq.size() && seq[lead] == 2) lead++;
    check("starve_d_run", lead, 4);
    check("starve_i_forced", (seq.size() > 5) ? seq[4] : 0, 1);
    check("starve_d_again", (seq.size() > 5) ? seq[5] : 0, 2);
    cycle_start(); bus.if_req = 0; bus.d_req = 0; cycle_end();
    idle_cycles(4);

    // Reset in the middle of a load.
    cycle_start(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; cycle_end();
    check("rstmid_gnt", bus.d_gnt, 1);
    cycle_start(); rst = 0; cycle_end();
    check("rstmid_d_rdata", bus.d_rdata, 0);
    check("rstmid_gnt_low", bus.d_gnt, 0);
    idle_cycles(1);
    cycle_start(); rst = 1; cycle_end();
    check("rstmid_no_valid", bus.d_valid, 0);
    check("rstmid_regrant", bus.d_gnt, 1);
    idle_cycles(2);
    cycle_start(); bus.d_req = 0; cycle_end();
    check("rstmid_valid", bus.d_valid, 1);
    check("rstmid_rdata", bus.d_rdata, 32'hDEAD_BEEF);

    // Fetch withdrawn after grant still completes.
    cycle_start(); bus.if_req = 1; bus.if_addr = 32'h20; cycle_end();
    check("wd_gnt", bus.if_gnt, 1);
    cycle_start(); bus.if_req = 0; cycle_end();
    idle_cycles(1);
    cycle_start(); cycle_end();
    check("wd_valid", bus.if_valid, 1);
    check("wd_rdata", bus.if_rdata, init_val(32'h20));
    idle_cycles(1);
    check("wd_no_regrant", bus.mem_en, 0);

    // Randomized requesters with occasional resets.
    i_st = 0; d_st = 0; rst_hold = 0; i_granted = 0; d_granted = 0;
    for (int n = 0; n < 3000; n++) begin
      cycle_start();
      if (rst_hold > 0) begin
        rst = 0; rst_hold--;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 0; rst_hold = $urandom_range(0, 1);
        i_granted = 0; d_granted = 0;
        if (i_st == 2) i_st = 0;
        if (d_st == 2) d_st = 0;
      end else begin
        rst = 1;
      end

      if (i_st != 0 && bus.if_valid === 1'b1) begin
        i_granted = 0;
        if (i_st == 1 && $urandom_range(0, 1) == 0) begin
          bus.if_addr = 32'($urandom_range(0, 15)) << 2;
        end else begin
          bus.if_req = 0; i_st = 0;
        end
      end else if (i_st == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.if_req = 1; bus.if_addr = 32'($urandom_range(0, 15)) << 2; i_st = 1;
        end
      end else if (i_st == 1 && i_granted && $urandom_range(0, 9) == 0) begin
        bus.if_req = 0; i_st = 2;
      end

      if (d_st != 0 && bus.d_valid === 1'b1) begin
        d_granted = 0;
        if (d_st == 1 && $urandom_range(0, 1) == 0) begin
          bus.d_we = 1'($urandom_range(0, 1));
          bus.d_addr = 32'($urandom_range(0, 15)) << 2;
          bus.d_wdata = $urandom;
        end else begin
          bus.d_req = 0; d_st = 0;
        end
      end else if (d_st == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1));
          bus.d_addr = 32'($urandom_range(0, 15)) << 2;
          bus.d_wdata = $urandom; d_st = 1;
        end
      end else if (d_st == 1 && d_granted && $urandom_range(0, 9) == 0) begin
        bus.d_req = 0; d_st = 2;
      end

      cycle_end();
      if (bus.if_gnt === 1'b1) i_granted = 1;
      if (bus.d_gnt === 1'b1) d_granted = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
